// File: rtl/riscv_pkg.sv
// Shared definitions for the ID/EX operand fetch slice: datapath widths and
// the forwarding-source selector used by each operand mux.
package riscv_pkg;

  localparam int XLEN       = 64;
  localparam int CTRL_W     = 16;
  localparam int CNT_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_RF   = 3'd4
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode-side and EX-side handshake bundle of the operand fetch stage.
// The stage itself uses the master view; the neighbouring pipeline uses the slave view.
interface operand_fetch_stage_if #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W
);

  logic                               dec_valid_in;
  logic                               dec_ready_out;
  logic [riscv_pkg::REG_ADDR_W-1:0]   dec_rs1_in;
  logic [riscv_pkg::REG_ADDR_W-1:0]   dec_rs2_in;
  logic                               dec_uses_rs1_in;
  logic                               dec_uses_rs2_in;
  logic [riscv_pkg::REG_ADDR_W-1:0]   dec_rd_in;
  logic                               dec_wr_en_in;
  logic                               dec_is_load_in;
  logic [XLEN-1:0]                    dec_imm_in;
  logic [XLEN-1:0]                    dec_pc_in;
  logic [CTRL_W-1:0]                  dec_ctrl_in;

  logic                               ex_valid_out;
  logic                               ex_ready_in;
  logic [XLEN-1:0]                    ex_op1_out;
  logic [XLEN-1:0]                    ex_op2_out;
  logic [XLEN-1:0]                    ex_imm_out;
  logic [XLEN-1:0]                    ex_pc_out;
  logic [riscv_pkg::REG_ADDR_W-1:0]   ex_rd_out;
  logic                               ex_wr_en_out;
  logic                               ex_is_load_out;
  logic [CTRL_W-1:0]                  ex_ctrl_out;

  modport master (
    input  dec_valid_in, dec_rs1_in, dec_rs2_in, dec_uses_rs1_in, dec_uses_rs2_in,
           dec_rd_in, dec_wr_en_in, dec_is_load_in, dec_imm_in, dec_pc_in, dec_ctrl_in,
           ex_ready_in,
    output dec_ready_out,
           ex_valid_out, ex_op1_out, ex_op2_out, ex_imm_out, ex_pc_out,
           ex_rd_out, ex_wr_en_out, ex_is_load_out, ex_ctrl_out
  );

  modport slave (
    output dec_valid_in, dec_rs1_in, dec_rs2_in, dec_uses_rs1_in, dec_uses_rs2_in,
           dec_rd_in, dec_wr_en_in, dec_is_load_in, dec_imm_in, dec_pc_in, dec_ctrl_in,
           ex_ready_in,
    input  dec_ready_out,
           ex_valid_out, ex_op1_out, ex_op2_out, ex_imm_out, ex_pc_out,
           ex_rd_out, ex_wr_en_out, ex_is_load_out, ex_ctrl_out
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: x0, then youngest in-flight producer (EX, MEM, WB),
// then the register file read data.
module operand_fwd_mux #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [riscv_pkg::REG_ADDR_W-1:0] rs_in,
  input  logic                             ex_valid_in,
  input  logic                             ex_wr_en_in,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ex_rd_in,
  input  logic [XLEN-1:0]                  ex_result_in,
  input  logic                             mem_wr_en_in,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] mem_rd_in,
  input  logic [XLEN-1:0]                  mem_result_in,
  input  logic                             wb_wr_en_in,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] wb_rd_in,
  input  logic [XLEN-1:0]                  wb_data_in,
  input  logic [XLEN-1:0]                  rf_data_in,
  output logic [XLEN-1:0]                  data_out
);

  import riscv_pkg::*;

  fwd_sel_e sel;

  // Source priority; checking x0 first also guarantees no forward from rd==0.
  always_comb begin
    sel = FWD_RF;
    if (rs_in == {REG_ADDR_W{1'b0}}) begin
      sel = FWD_ZERO;
    end else if (ex_valid_in && ex_wr_en_in && (ex_rd_in == rs_in)) begin
      sel = FWD_EX;
    end else if (mem_wr_en_in && (mem_rd_in == rs_in)) begin
      sel = FWD_MEM;
    end else if (wb_wr_en_in && (wb_rd_in == rs_in)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

  // Data mux driven by the selected source.
  always_comb begin
    data_out = rf_data_in;
    case (sel)
      FWD_ZERO: data_out = {XLEN{1'b0}};
      FWD_EX:   data_out = ex_result_in;
      FWD_MEM:  data_out = mem_result_in;
      FWD_WB:   data_out = wb_data_in;
      FWD_RF:   data_out = rf_data_in;
      default:  data_out = rf_data_in;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// ID->EX stage: drives reg_file read addresses, resolves forwarded operands,
// inserts load-use bubbles and holds the ID/EX pipeline register.
module operand_fetch_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int CTRL_W = riscv_pkg::CTRL_W,
  parameter int CNT_W  = riscv_pkg::CNT_W
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  operand_fetch_stage_if.master            pipe,
  output logic [riscv_pkg::REG_ADDR_W-1:0] rs1_out,
  output logic [riscv_pkg::REG_ADDR_W-1:0] rs2_out,
  input  logic [XLEN-1:0]                  reg_data1_in,
  input  logic [XLEN-1:0]                  reg_data2_in,
  input  logic [XLEN-1:0]                  ex_result_in,
  input  logic                             mem_wr_en_in,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] mem_rd_in,
  input  logic [XLEN-1:0]                  mem_result_in,
  input  logic                             wb_wr_en_in,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] wb_rd_in,
  input  logic [XLEN-1:0]                  wb_data_in,
  input  logic                             flush_in,
  output logic [CNT_W-1:0]                 stall_cnt_out
);

  import riscv_pkg::*;

  logic                  load_en;
  logic                  hazard;
  logic [XLEN-1:0]       op1_res;
  logic [XLEN-1:0]       op2_res;

  logic                  valid_d,   valid_q;
  logic [XLEN-1:0]       op1_d,     op1_q;
  logic [XLEN-1:0]       op2_d,     op2_q;
  logic [XLEN-1:0]       imm_d,     imm_q;
  logic [XLEN-1:0]       pc_d,      pc_q;
  logic [REG_ADDR_W-1:0] rd_d,      rd_q;
  logic                  wr_en_d,   wr_en_q;
  logic                  is_load_d, is_load_q;
  logic [CTRL_W-1:0]     ctrl_d,    ctrl_q;
  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;

  assign rs1_out = pipe.dec_rs1_in;
  assign rs2_out = pipe.dec_rs2_in;

  assign load_en = !valid_q || pipe.ex_ready_in;
  assign hazard  = valid_q && is_load_q && wr_en_q && (rd_q != {REG_ADDR_W{1'b0}}) &&
                   ((pipe.dec_uses_rs1_in && (pipe.dec_rs1_in == rd_q)) ||
                    (pipe.dec_uses_rs2_in && (pipe.dec_rs2_in == rd_q)));
  assign pipe.dec_ready_out = flush_in || (load_en && !hazard);

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs_in         (pipe.dec_rs1_in),
    .ex_valid_in   (valid_q),
    .ex_wr_en_in   (wr_en_q),
    .ex_rd_in      (rd_q),
    .ex_result_in  (ex_result_in),
    .mem_wr_en_in  (mem_wr_en_in),
    .mem_rd_in     (mem_rd_in),
    .mem_result_in (mem_result_in),
    .wb_wr_en_in   (wb_wr_en_in),
    .wb_rd_in      (wb_rd_in),
    .wb_data_in    (wb_data_in),
    .rf_data_in    (reg_data1_in),
    .data_out      (op1_res)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs_in         (pipe.dec_rs2_in),
    .ex_valid_in   (valid_q),
    .ex_wr_en_in   (wr_en_q),
    .ex_rd_in      (rd_q),
    .ex_result_in  (ex_result_in),
    .mem_wr_en_in  (mem_wr_en_in),
    .mem_rd_in     (mem_rd_in),
    .mem_result_in (mem_result_in),
    .wb_wr_en_in   (wb_wr_en_in),
    .wb_rd_in      (wb_rd_in),
    .wb_data_in    (wb_data_in),
    .rf_data_in    (reg_data2_in),
    .data_out      (op2_res)
  );

  // Next pipeline-register state: flush beats bubble beats capture beats hold.
  always_comb begin
    valid_d     = valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    wr_en_d     = wr_en_q;
    is_load_d   = is_load_q;
    ctrl_d      = ctrl_q;
    stall_cnt_d = stall_cnt_q;
    if (flush_in) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
    end else if (load_en && hazard && pipe.dec_valid_in) begin
      valid_d = 1'b0;
      wr_en_d = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else if (load_en) begin
      valid_d   = pipe.dec_valid_in;
      op1_d     = op1_res;
      op2_d     = op2_res;
      imm_d     = pipe.dec_imm_in;
      pc_d      = pipe.dec_pc_in;
      rd_d      = pipe.dec_rd_in;
      wr_en_d   = pipe.dec_wr_en_in;
      is_load_d = pipe.dec_is_load_in;
      ctrl_d    = pipe.dec_ctrl_in;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register and stall counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q     <= 1'b0;
      op1_q       <= {XLEN{1'b0}};
      op2_q       <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      pc_q        <= {XLEN{1'b0}};
      rd_q        <= {REG_ADDR_W{1'b0}};
      wr_en_q     <= 1'b0;
      is_load_q   <= 1'b0;
      ctrl_q      <= {CTRL_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      wr_en_q     <= wr_en_d;
      is_load_q   <= is_load_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pipe.ex_valid_out   = valid_q;
  assign pipe.ex_op1_out     = op1_q;
  assign pipe.ex_op2_out     = op2_q;
  assign pipe.ex_imm_out     = imm_q;
  assign pipe.ex_pc_out      = pc_q;
  assign pipe.ex_rd_out      = rd_q;
  assign pipe.ex_wr_en_out   = wr_en_q;
  assign pipe.ex_is_load_out = is_load_q;
  assign pipe.ex_ctrl_out    = ctrl_q;
  assign stall_cnt_out       = stall_cnt_q;

endmodule
